// File: rtl/maxpool2_layer.sv
// 2x2 stride-2 signed max pooling over nine parallel channels of a raster-order feature map.
// One pooled sample per channel is emitted one cycle after the bottom-right pixel of each window.
module maxpool2_layer #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] conv1_in,
  input  logic signed [DATA_BITS-1:0] conv2_in,
  input  logic signed [DATA_BITS-1:0] conv3_in,
  input  logic signed [DATA_BITS-1:0] conv4_in,
  input  logic signed [DATA_BITS-1:0] conv5_in,
  input  logic signed [DATA_BITS-1:0] conv6_in,
  input  logic signed [DATA_BITS-1:0] conv7_in,
  input  logic signed [DATA_BITS-1:0] conv8_in,
  input  logic signed [DATA_BITS-1:0] conv9_in,
  output logic signed [DATA_BITS-1:0] pool1_out,
  output logic signed [DATA_BITS-1:0] pool2_out,
  output logic signed [DATA_BITS-1:0] pool3_out,
  output logic signed [DATA_BITS-1:0] pool4_out,
  output logic signed [DATA_BITS-1:0] pool5_out,
  output logic signed [DATA_BITS-1:0] pool6_out,
  output logic signed [DATA_BITS-1:0] pool7_out,
  output logic signed [DATA_BITS-1:0] pool8_out,
  output logic signed [DATA_BITS-1:0] pool9_out,
  output logic                        valid_out,
  output logic                        frame_done
);

  localparam int NCH = 9;
  localparam int HALF_W = WIDTH / 2;
  localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int LW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [LW-1:0] lidx;
  logic          last_col;
  logic          last_row;

  logic signed [DATA_BITS-1:0] din      [NCH];
  logic signed [DATA_BITS-1:0] hold     [NCH];
  logic signed [DATA_BITS-1:0] lbuf     [NCH][HALF_W];
  logic signed [DATA_BITS-1:0] pool     [NCH];
  logic signed [DATA_BITS-1:0] pair_max [NCH];
  logic signed [DATA_BITS-1:0] win_max  [NCH];

  function automatic logic signed [DATA_BITS-1:0] smax(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign din[0] = conv1_in;
  assign din[1] = conv2_in;
  assign din[2] = conv3_in;
  assign din[3] = conv4_in;
  assign din[4] = conv5_in;
  assign din[5] = conv6_in;
  assign din[6] = conv7_in;
  assign din[7] = conv8_in;
  assign din[8] = conv9_in;

  assign pool1_out = pool[0];
  assign pool2_out = pool[1];
  assign pool3_out = pool[2];
  assign pool4_out = pool[3];
  assign pool5_out = pool[4];
  assign pool6_out = pool[5];
  assign pool7_out = pool[6];
  assign pool8_out = pool[7];
  assign pool9_out = pool[8];

  assign lidx     = LW'(col_cnt >> 1);
  assign last_col = (col_cnt == CW'(WIDTH - 1));
  assign last_row = (row_cnt == RW'(HEIGHT - 1));

  // Top-row pair max goes to the line buffer; bottom-row pair max merges with it.
  always_comb begin
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      pair_max[ch] = smax(hold[ch], din[ch]);
      win_max[ch]  = smax(lbuf[ch][lidx], pair_max[ch]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        hold[ch] <= '0;
        pool[ch] <= '0;
        for (int unsigned i = 0; i < HALF_W; i++) lbuf[ch][i] <= '0;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (!col_cnt[0]) begin
          for (int unsigned ch = 0; ch < NCH; ch++) hold[ch] <= din[ch];
        end else if (!row_cnt[0]) begin
          for (int unsigned ch = 0; ch < NCH; ch++) lbuf[ch][lidx] <= pair_max[ch];
        end else begin
          for (int unsigned ch = 0; ch < NCH; ch++) pool[ch] <= win_max[ch];
          valid_out  <= 1'b1;
          frame_done <= last_row && last_col;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2_layer.sv
// Bench for maxpool2_layer: every accepted pixel is stored into a full-frame image model and each
// odd/odd pixel yields the expected window max, compared cycle by cycle against the DUT.
module tb_maxpool2_layer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DB = 16;
  localparam int NOUT = (W / 2) * (H / 2);

  logic clk, rst, valid_in;
  logic signed [DB-1:0] conv [9];
  logic signed [DB-1:0] pool [9];
  logic valid_out, frame_done;

  maxpool2_layer #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .conv1_in(conv[0]), .conv2_in(conv[1]), .conv3_in(conv[2]),
    .conv4_in(conv[3]), .conv5_in(conv[4]), .conv6_in(conv[5]),
    .conv7_in(conv[6]), .conv8_in(conv[7]), .conv9_in(conv[8]),
    .pool1_out(pool[0]), .pool2_out(pool[1]), .pool3_out(pool[2]),
    .pool4_out(pool[3]), .pool5_out(pool[4]), .pool6_out(pool[5]),
    .pool7_out(pool[6]), .pool8_out(pool[7]), .pool9_out(pool[8]),
    .valid_out(valid_out), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: whole-frame image plus write position.
  logic signed [DB-1:0] mimg [9][H][W];
  logic signed [DB-1:0] exp_pool [9];
  int mr = 0, mc = 0;
  int npulse = 0, nfd = 0;
  logic signed [DB-1:0] outq [$];
  logic signed [DB-1:0] rampq [$];

  function automatic logic signed [DB-1:0] mx(input logic signed [DB-1:0] a, input logic signed [DB-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v);
    logic exp_v, exp_fd;
    valid_in = v;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      for (int ch = 0; ch < 9; ch++) mimg[ch][mr][mc] = conv[ch];
      if ((mr % 2 == 1) && (mc % 2 == 1)) begin
        exp_v = 1'b1;
        exp_fd = (mr == H - 1) && (mc == W - 1);
        for (int ch = 0; ch < 9; ch++)
          exp_pool[ch] = mx(mx(mimg[ch][mr-1][mc-1], mimg[ch][mr-1][mc]),
                            mx(mimg[ch][mr][mc-1], mimg[ch][mr][mc]));
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
    chk("valid_out", valid_out, exp_v);
    chk("frame_done", frame_done, exp_fd);
    for (int ch = 0; ch < 9; ch++) chk($sformatf("pool%0d", ch + 1), pool[ch], exp_pool[ch]);
    if (valid_out) begin
      npulse++;
      outq.push_back(pool[0]);
    end
    if (frame_done) nfd++;
  endtask

  // kind: 0 ramp, 1 random, 2 signed pattern, 3 all minimum, 4 max-position
  // gaps: 0 none, 1 alternate, 2 random
  task automatic send(input int kind, input int gaps, input int n);
    int sent = 0;
    int t = 0;
    int r, c, p, wi;
    while (sent < n) begin
      if ((gaps == 1 && (t % 2 == 1)) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
        for (int ch = 0; ch < 9; ch++) conv[ch] = DB'($urandom);
        cyc(1'b0);
      end else begin
        r = (sent / W) % H;
        c = sent % W;
        p = (r % 2) * 2 + (c % 2);
        wi = (r / 2) * (W / 2) + (c / 2);
        for (int ch = 0; ch < 9; ch++) begin
          case (kind)
            0: conv[ch] = DB'((ch + 1) * 100 + r * W + c);
            1: conv[ch] = DB'($urandom);
            2: conv[ch] = (p == 0) ? -16'sd5 : (p == 1) ? -16'sd3 : (p == 2) ? -16'sd32768 : -16'sd4;
            3: conv[ch] = -16'sd32768;
            default: conv[ch] = (p == wi % 4) ? 16'sd1000 : DB'(int'($urandom_range(0, 1999)) - 1000);
          endcase
        end
        cyc(1'b1);
        sent++;
      end
      t++;
    end
  endtask

  task automatic start_test();
    npulse = 0;
    nfd = 0;
    outq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    for (int ch = 0; ch < 9; ch++) chk($sformatf("rst_pool%0d", ch + 1), pool[ch], 0);
    for (int ch = 0; ch < 9; ch++) exp_pool[ch] = '0;
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    for (int ch = 0; ch < 9; ch++) conv[ch] = '0;
    #2;
    do_reset();

    // Continuous ramp
    start_test();
    send(0, 0, W * H);
    chk("ramp_pulses", npulse, NOUT);
    chk("ramp_frame_done", nfd, 1);
    if (outq.size() > 0) chk("ramp_first", outq[0], 109);
    chk("ramp_pool9_last", pool[8], 900 + 7 * W + 7);
    rampq = outq;

    // Ramp with alternating gaps
    start_test();
    send(0, 1, W * H);
    chk("gap_pulses", npulse, NOUT);
    chk("gap_frame_done", nfd, 1);
    for (int i = 0; i < outq.size() && i < rampq.size(); i++) chk("gap_order", outq[i], rampq[i]);

    // Back-to-back frames
    start_test();
    send(0, 0, 2 * W * H);
    chk("b2b_pulses", npulse, 2 * NOUT);
    chk("b2b_frame_done", nfd, 2);
    for (int i = 0; i < NOUT && i + NOUT < outq.size(); i++) chk("b2b_repeat", outq[i + NOUT], outq[i]);

    // Signed pattern and all-minimum frames
    start_test();
    send(2, 0, W * H);
    chk("signed_pulses", npulse, NOUT);
    for (int i = 0; i < outq.size(); i++) chk("signed_val", outq[i], -3);
    start_test();
    send(3, 2, W * H);
    for (int i = 0; i < outq.size(); i++) chk("allmin_val", outq[i], -32768);

    // Maximum in each window position
    start_test();
    send(4, 0, W * H);
    chk("maxpos_pulses", npulse, NOUT);
    for (int i = 0; i < outq.size(); i++) chk("maxpos_val", outq[i], 1000);

    // Reset mid-frame then full ramp
    send(1, 0, 20);
    #2;
    do_reset();
    start_test();
    send(0, 0, W * H);
    chk("rstmid_pulses", npulse, NOUT);
    chk("rstmid_frame_done", nfd, 1);
    for (int i = 0; i < outq.size() && i < rampq.size(); i++) chk("rstmid_val", outq[i], rampq[i]);

    // Random data with random gaps
    for (int f = 0; f < 3; f++) begin
      start_test();
      send(1, 2, W * H);
      chk("rand_pulses", npulse, NOUT);
      chk("rand_frame_done", nfd, 1);
    end

    for (int i = 0; i < 4; i++) cyc(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
